cache_arbiter: RTL and testbench

Arbitrates the single physical-memory port between the instruction cache and the data cache. Sits between the two cache instances' pmem-side interfaces and physical memory. Grants one requester at a time, forwards its read/write strobe, address and write line, and returns the memory response only to the granted cache. Each grant is held for exactly one complete memory transaction.

---
 rtl/cache_arbiter_if.sv | 20 ++
 rtl/cache_arbiter.sv | 102 ++++++++++
 tb/tb_cache_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Cache-to-physical-memory line port. The requester drives the master side and
// the responder drives the slave side. Address is a 16-bit word, data is a 128-bit cache line.
interface cache_arbiter_if;
  logic         read;
  logic         write;
  logic [15:0]  address;
  logic [127:0] wdata;
  logic         resp;
  logic [127:0] rdata;

  modport master (
    output read, write, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata,
    output resp, rdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and the D-cache. A grant lasts for one
// whole memory transaction. CACHE_ARB_RR_EN selects round-robin on conflict; without it, D wins.
module cache_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  cache_arbiter_if.slave  i_pmem,
  cache_arbiter_if.slave  d_pmem,
  cache_arbiter_if.master pmem
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT_I,
    ST_GRANT_D,
    ST_RECOVER
  } state_e;

  typedef enum logic {
    SRC_I,
    SRC_D
  } src_e;

  state_e state_q, state_d;
  src_e   last_grant_q, last_grant_d;
  src_e   conflict_winner;
  logic   i_req, d_req;

  assign i_req = i_pmem.read | i_pmem.write;
  assign d_req = d_pmem.read | d_pmem.write;

`ifdef CACHE_ARB_RR_EN
  assign conflict_winner = (last_grant_q == SRC_I) ? SRC_D : SRC_I;
`else
  assign conflict_winner = SRC_D;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req && d_req) begin
          state_d      = (conflict_winner == SRC_I) ? ST_GRANT_I : ST_GRANT_D;
          last_grant_d = conflict_winner;
        end else if (i_req) begin
          state_d      = ST_GRANT_I;
          last_grant_d = SRC_I;
        end else if (d_req) begin
          state_d      = ST_GRANT_D;
          last_grant_d = SRC_D;
        end
      end
      ST_GRANT_I,
      ST_GRANT_D: begin
        if (pmem.resp) state_d = ST_RECOVER;
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // RECOVER keeps the port quiet for one cycle so the served cache can drop its stale strobe.
  always_comb begin
    pmem.read    = 1'b0;
    pmem.write   = 1'b0;
    pmem.address = '0;
    pmem.wdata   = '0;
    unique case (state_q)
      ST_GRANT_I: begin
        pmem.read    = i_pmem.read;
        pmem.write   = i_pmem.write;
        pmem.address = i_pmem.address;
        pmem.wdata   = i_pmem.wdata;
      end
      ST_GRANT_D: begin
        pmem.read    = d_pmem.read;
        pmem.write   = d_pmem.write;
        pmem.address = d_pmem.address;
        pmem.wdata   = d_pmem.wdata;
      end
      default: ;
    endcase
  end

  assign i_pmem.resp  = pmem.resp & (state_q == ST_GRANT_I);
  assign d_pmem.resp  = pmem.resp & (state_q == ST_GRANT_D);
  assign i_pmem.rdata = pmem.rdata;
  assign d_pmem.rdata = pmem.rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter. Random cache traffic and a random-latency memory are
// compared against a transaction-level arbitration model.
module tb_cache_arbiter;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_arbiter_if i_bus ();
  cache_arbiter_if d_bus ();
  cache_arbiter_if m_bus ();

  cache_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pmem (i_bus),
    .d_pmem (d_bus),
    .pmem   (m_bus)
  );

  // Cache-side drive: index 0 = I-cache, 1 = D-cache.
  logic         req_rd    [2];
  logic         req_wr    [2];
  logic [15:0]  req_addr  [2];
  logic [127:0] req_wdata [2];
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  assign i_bus.read    = req_rd[0];
  assign i_bus.write   = req_wr[0];
  assign i_bus.address = req_addr[0];
  assign i_bus.wdata   = req_wdata[0];
  assign d_bus.read    = req_rd[1];
  assign d_bus.write   = req_wr[1];
  assign d_bus.address = req_addr[1];
  assign d_bus.wdata   = req_wdata[1];
  assign m_bus.resp    = pmem_resp;
  assign m_bus.rdata   = pmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  txn_t exp_q_i[$];
  txn_t exp_q_d[$];

  bit   model_on = 1'b0;
  bit   mem_auto = 1'b0;
  bit   in_txn, prev_i, prev_d, cur_i, cur_d;
  int   ready_cyc, gnt, last_gnt;
  txn_t cur_txn;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Arbitration rule: a lone requester wins; on conflict the policy decides.
  function automatic int pick(bit pi, bit pd, int last);
    if (pi && pd) begin
`ifdef CACHE_ARB_RR_EN
      return (last == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return pd ? 1 : 0;
  endfunction

  // Memory: random 0..4 cycle latency per transaction, plus occasional spurious resp when idle.
  initial begin
    int  cnt;
    bit  busy;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_auto) begin
        pmem_rdata = rand_line();
        if (m_bus.read || m_bus.write) begin
          if (!busy) begin
            busy = 1'b1;
            cnt  = $urandom_range(0, 4);
          end
          if (cnt == 0) begin
            pmem_resp = 1'b1;
            busy      = 1'b0;
          end else begin
            cnt--;
            pmem_resp = 1'b0;
          end
        end else begin
          busy      = 1'b0;
          pmem_resp = ($urandom_range(0, 7) == 0);
        end
      end
    end
  end

  // Monitor. The arbiter may start a new grant only two cycles after a response cycle.
  // A request pending while the arbiter is free shows on the port in the following cycle.
  always @(negedge clk) begin
    if (model_on) begin
      cur_i = req_rd[0] | req_wr[0];
      cur_d = req_rd[1] | req_wr[1];
      if (!in_txn && (cyc - 1 >= ready_cyc) && (prev_i || prev_d)) begin
        gnt = pick(prev_i, prev_d, last_gnt);
        if (gnt == 0 && exp_q_i.size() > 0) cur_txn = exp_q_i.pop_front();
        else if (gnt == 1 && exp_q_d.size() > 0) cur_txn = exp_q_d.pop_front();
        else check("grant_has_expected_txn", 1'b0, 1'b1);
        last_gnt = gnt;
        in_txn   = 1'b1;
      end
      if (in_txn) begin
        check(gnt ? "grant_d_port" : "grant_i_port",
              {m_bus.read, m_bus.write, m_bus.address, m_bus.wdata},
              {cur_txn.rd, cur_txn.wr, cur_txn.addr, cur_txn.wdata});
        check(gnt ? "resp_d" : "resp_i", gnt ? d_bus.resp : i_bus.resp, pmem_resp);
        check(gnt ? "resp_i_quiet" : "resp_d_quiet", gnt ? i_bus.resp : d_bus.resp, 1'b0);
        if (pmem_resp) begin
          check("rdata", gnt ? d_bus.rdata : i_bus.rdata, pmem_rdata);
          in_txn    = 1'b0;
          ready_cyc = cyc + 2;
        end
      end else begin
        check("idle_port", {m_bus.read, m_bus.write, m_bus.address, m_bus.wdata}, '0);
        check("idle_resp", {i_bus.resp, d_bus.resp}, 2'b00);
      end
      prev_i = cur_i;
      prev_d = cur_d;
    end
  end

  // One cache: random gaps, random op; holds until resp, then drops in the next cycle.
  task automatic drive_cache(input int c, input int n);
    txn_t t;
    int   waited;
    bit   got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      #1;
      t.rd    = $urandom_range(0, 1);
      t.wr    = t.rd ? ($urandom_range(0, 5) == 0) : 1'b1;
      t.addr  = 16'($urandom);
      t.wdata = rand_line();
      if (c == 0) exp_q_i.push_back(t);
      else        exp_q_d.push_back(t);
      req_rd[c]    = t.rd;
      req_wr[c]    = t.wr;
      req_addr[c]  = t.addr;
      req_wdata[c] = t.wdata;
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 400) begin
        @(negedge clk);
        waited++;
        got = (c == 0) ? i_bus.resp : d_bus.resp;
      end
      check(c ? "d_served_in_time" : "i_served_in_time", got, 1'b1);
      @(posedge clk);
      #1;
      req_rd[c] = 1'b0;
      req_wr[c] = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    for (int c = 0; c < 2; c++) begin
      req_rd[c]    = 1'b0;
      req_wr[c]    = 1'b0;
      req_addr[c]  = '0;
      req_wdata[c] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_port", {m_bus.read, m_bus.write, m_bus.address, m_bus.wdata}, '0);
    check("reset_resp", {i_bus.resp, d_bus.resp}, 2'b00);

    // Spurious memory response while idle.
    @(posedge clk);
    #1;
    pmem_resp  = 1'b1;
    pmem_rdata = {4{32'hDEADBEEF}};
    @(negedge clk);
    check("spurious_resp", {i_bus.resp, d_bus.resp}, 2'b00);
    @(negedge clk);
    check("spurious_still_idle", {m_bus.read, m_bus.write, m_bus.address}, '0);
    @(posedge clk);
    #1 pmem_resp = 1'b0;

    // Lone D write; one-cycle grant latency; then reset mid-grant abandons it.
    @(posedge clk);
    #1;
    req_wr[1]    = 1'b1;
    req_addr[1]  = 16'h4440;
    req_wdata[1] = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    @(negedge clk);
    check("grant_latency", m_bus.write, 1'b0);
    @(negedge clk);
    check("d_write_port", {m_bus.read, m_bus.write, m_bus.address, m_bus.wdata},
          {1'b0, 1'b1, 16'h4440, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF});
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    pmem_resp = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_mid_grant_port", {m_bus.read, m_bus.write, m_bus.address}, '0);
    check("reset_mid_grant_resp", d_bus.resp, 1'b0);
    @(posedge clk);
    #1;
    req_wr[1] = 1'b0;
    pmem_resp = 1'b0;
    rst_n     = 1'b1;

    // Randomized phase under the model; arbiter is idle with last grant = I.
    @(posedge clk);
    #3;
    in_txn    = 1'b0;
    prev_i    = 1'b0;
    prev_d    = 1'b0;
    last_gnt  = 0;
    ready_cyc = cyc;
    mem_auto  = 1'b1;
    model_on  = 1'b1;
    fork
      drive_cache(0, 40);
      drive_cache(1, 40);
    join
    repeat (3) @(posedge clk);
    #3;
    mem_auto  = 1'b0;
    pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    model_on = 1'b0;
    check("all_i_txns_granted", 32'(exp_q_i.size()), 32'd0);
    check("all_d_txns_granted", 32'(exp_q_d.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
